// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: cmd handshake (cmd_*), external ALU drive/result (alu_*), response handshake (rsp_*) and op_count of alu_issue_ctrl
interface alu_issue_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] alu_ope;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic [2:0] rsp_op;
  logic       rsp_zero;
  logic [7:0] op_count;
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, rsp_ready,
    input  cmd_ready, alu_ope, alu_a, alu_b, rsp_valid, rsp_data, rsp_op, rsp_zero, op_count
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, rsp_ready,
    output cmd_ready, alu_ope, alu_a, alu_b, rsp_valid, rsp_data, rsp_op, rsp_zero, op_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one command to an external ALU, holds operands SETTLE cycles, captures result into a 2-entry response FIFO (ports: clk, rst, bus slave)
module alu_issue_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input logic           clk,
  input logic           rst,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t     state_q;
  logic [3:0] cnt_q;
  logic [2:0] ope_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [8:0] fifo_q [2];
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic [7:0] op_count_q;
  logic       accept;
  logic       push;
  logic       pop;
  logic [8:0] entry;
  always_comb begin
    accept  = bus.cmd_valid && state_q == IDLE && count_q != 2'd2;
    push    = state_q == DRIVE && cnt_q == 4'd1;
    pop     = count_q != 2'd0 && bus.rsp_ready;
    entry   = {bus.alu_out, ope_q, bus.alu_out == 5'd0};
    count_d = count_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ope_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (accept) begin
          ope_q   <= bus.cmd_op;
          a_q     <= bus.cmd_a;
          b_q     <= bus.cmd_b;
          cnt_q   <= 4'(SETTLE);
          state_q <= DRIVE;
        end
      end else begin
        cnt_q <= cnt_q - 4'd1;
        if (push) begin
          state_q    <= IDLE;
          op_count_q <= op_count_q + 8'd1;
        end
      end
      // a push only ever lands in a FIFO holding at most one entry
      if (pop) fifo_q[0] <= (push && count_q == 2'd1) ? entry : fifo_q[1];
      else if (push) fifo_q[count_q[0]] <= entry;
      count_q <= count_d;
    end
  end
  assign bus.cmd_ready = state_q == IDLE && count_q != 2'd2;
  assign bus.alu_ope   = ope_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.rsp_valid = count_q != 2'd0;
  assign bus.rsp_data  = fifo_q[0][8:4];
  assign bus.rsp_op    = fifo_q[0][3:1];
  assign bus.rsp_zero  = fifo_q[0][0];
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: two alu_issue_ctrl lanes (SETTLE 1 and 3) on shared stimulus, checked against a transaction-level model
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       cv = 1'b0;
  logic       rr = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [4:0] noise = '0;
  alu_issue_ctrl_if b0 ();
  alu_issue_ctrl_if b1 ();
  alu_issue_ctrl #(.SETTLE(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  alu_issue_ctrl #(.SETTLE(3)) u1 (.clk(clk), .rst(rst), .bus(b1));
  function automatic logic [4:0] alu_f(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] p;
    logic [4:0] q;
    p = {1'b0, x};
    q = {1'b0, y};
    case (o)
      3'd1: return p & q;
      3'd2: return p | q;
      3'd3: return p ^ q;
      3'd4: return p << 1;
      3'd5: return p - q;
      3'd7: return ~(p & q);
      default: return p + q;
    endcase
  endfunction
  assign b0.cmd_valid = cv;
  assign b0.rsp_ready = rr;
  assign b0.cmd_op    = op;
  assign b0.cmd_a     = a;
  assign b0.cmd_b     = b;
  assign b0.alu_out   = alu_f(b0.alu_ope, b0.alu_a, b0.alu_b) ^ noise;
  assign b1.cmd_valid = cv;
  assign b1.rsp_ready = rr;
  assign b1.cmd_op    = op;
  assign b1.cmd_a     = a;
  assign b1.cmd_b     = b;
  assign b1.alu_out   = alu_f(b1.alu_ope, b1.alu_a, b1.alu_b) ^ noise;
  logic        rdy [2];
  logic        vld [2];
  logic [8:0]  head [2];
  logic [10:0] drv [2];
  logic [7:0]  cnt [2];
  assign rdy[0]  = b0.cmd_ready;
  assign rdy[1]  = b1.cmd_ready;
  assign vld[0]  = b0.rsp_valid;
  assign vld[1]  = b1.rsp_valid;
  assign head[0] = {b0.rsp_data, b0.rsp_op, b0.rsp_zero};
  assign head[1] = {b1.rsp_data, b1.rsp_op, b1.rsp_zero};
  assign drv[0]  = {b0.alu_ope, b0.alu_a, b0.alu_b};
  assign drv[1]  = {b1.alu_ope, b1.alu_a, b1.alu_b};
  assign cnt[0]  = b0.op_count;
  assign cnt[1]  = b1.op_count;
  int          cyc = 0;
  bit          fly [2];
  int          done_at [2];
  logic [10:0] cur [2];
  logic [8:0]  mq [2][$];
  int          total [2];
  bit          fresh [2];
  int          tests = 0;
  int          fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    bit         ready;
    bit         pop;
    logic [4:0] r;
    cyc++;
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        fly[l] = 1'b0;
        mq[l].delete();
        total[l] = 0;
        cur[l] = '0;
        fresh[l] = 1'b1;
      end else begin
        ready = !fly[l] && mq[l].size() < 2;
        pop = mq[l].size() > 0 && rr;
        if (pop) void'(mq[l].pop_front());
        if (fly[l] && cyc == done_at[l]) begin
          r = alu_f(cur[l][10:8], cur[l][7:4], cur[l][3:0]) ^ noise;
          mq[l].push_back({r, cur[l][10:8], r == 5'd0});
          fly[l] = 1'b0;
          total[l]++;
          fresh[l] = 1'b0;
        end
        if (ready && cv) begin
          fly[l] = 1'b1;
          done_at[l] = cyc + (l == 0 ? 1 : 3);
          cur[l] = {op, a, b};
        end
      end
    end
  endtask
  task automatic check_all();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("l%0d cmd_ready", l), 32'(rdy[l]), 32'(!fly[l] && mq[l].size() < 2));
      check($sformatf("l%0d rsp_valid", l), 32'(vld[l]), 32'(mq[l].size() > 0));
      check($sformatf("l%0d op_count", l), 32'(cnt[l]), total[l] & 255);
      check($sformatf("l%0d alu_drive", l), 32'(drv[l]), 32'(cur[l]));
      if (mq[l].size() > 0) check($sformatf("l%0d rsp_head", l), 32'(head[l]), 32'(mq[l][0]));
      else if (fresh[l]) check($sformatf("l%0d rsp_reset", l), 32'(head[l]), 32'd0);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic idle(input int n);
    cv = 1'b0;
    repeat (n) step();
  endtask
  task automatic send(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    int n;
    n = 0;
    op = o;
    a = x;
    b = y;
    cv = 1'b1;
    while (!rdy[0] && n < 20) begin
      step();
      n++;
    end
    check("send_timeout", 32'(n < 20), 32'd1);
    step();
    cv = 1'b0;
  endtask
  logic [4:0] exp_r;
  initial begin
    step();
    step();
    rst = 1'b0;
    check("post_rst cmd_ready", 32'(rdy[0]), 32'd1);
    check("post_rst rsp_valid", 32'(vld[0]), 32'd0);
    rr = 1'b1;
    send(3'd6, 4'd9, 4'd8);
    check("r028 not_yet", 32'(vld[0]), 32'd0);
    step();
    check("r028 valid", 32'(vld[0]), 32'd1);
    check("r028 data", 32'(head[0]), 32'({5'h11, 3'd6, 1'b0}));
    check("r028 op_count", 32'(cnt[0]), 32'd1);
    idle(5);
    send(3'd7, 4'd3, 4'd5);
    step();
    check("r029 nand", 32'(head[0]), 32'({5'h1E, 3'd7, 1'b0}));
    idle(5);
    send(3'd4, 4'd5, 4'd0);
    step();
    check("r029 shl", 32'(head[0]), 32'({5'h0A, 3'd4, 1'b0}));
    idle(5);
    send(3'd1, 4'd4, 4'd3);
    step();
    check("r029 zero", 32'(head[0]), 32'({5'h00, 3'd1, 1'b1}));
    idle(6);
    rr = 1'b0;
    send(3'd6, 4'd1, 4'd1);
    send(3'd6, 4'd1, 4'd2);
    op = 3'd6;
    a = 4'd1;
    b = 4'd3;
    cv = 1'b1;
    repeat (2) step();
    check("r030 full ready", 32'(rdy[0]), 32'd0);
    check("r030 head2", 32'(head[0][8:4]), 32'd2);
    rr = 1'b1;
    step();
    rr = 1'b0;
    check("r030 head3", 32'(head[0][8:4]), 32'd3);
    check("r030 ready", 32'(rdy[0]), 32'd1);
    step();
    cv = 1'b0;
    step();
    check("r030 hold3", 32'(head[0][8:4]), 32'd3);
    rr = 1'b1;
    step();
    check("r030 head4", 32'(head[0][8:4]), 32'd4);
    idle(10);
    send(3'd0, 4'd7, 4'd6);
    for (int k = 1; k <= 3; k++) begin
      check("r031 drive", 32'(drv[1]), 32'({3'd0, 4'd7, 4'd6}));
      noise = 5'($urandom);
      exp_r = alu_f(3'd0, 4'd7, 4'd6) ^ noise;
      step();
      check("r031 valid", 32'(vld[1]), 32'(k == 3));
    end
    check("r031 final", 32'(head[1][8:4]), 32'(exp_r));
    noise = '0;
    idle(10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(3'd2, 4'd5, 4'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(5);
    check("r032 no_rsp0", 32'(vld[0]), 32'd0);
    check("r032 no_rsp1", 32'(vld[1]), 32'd0);
    check("r032 count", 32'(cnt[0]), 32'd0);
    send(3'd2, 4'd5, 4'd10);
    step();
    check("r032 recover", 32'(head[0]), 32'({5'h0F, 3'd2, 1'b0}));
    check("r032 count1", 32'(cnt[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cv = 1'b1;
    for (int i = 0; i < 2000 && total[0] < 256; i++) begin
      op = 3'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      step();
    end
    check("r033 reached", 32'(total[0]), 32'd256);
    check("r033 wrap", 32'(cnt[0]), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 399) == 0;
      cv = $urandom_range(0, 3) != 0;
      rr = $urandom_range(0, 2) != 0;
      op = 3'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      noise = i >= 1500 ? 5'($urandom) : 5'd0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
